dyt_decode_stage: RTL and testbench

- RV32E instruction decode stage. Sits between fetch and execute, and drives the read ports of the 16-entry register file (x0..x15, 4-bit addresses).
- Accepts one instruction per cycle over a valid/ready handshake and decodes opcode class, register fields and immediate.
- Reads both source operands from the register file and holds the result in a single-entry ID/EX pipeline register.
- A write-pending scoreboard stalls on RAW hazards. There is no bypass path.

---
 rtl/dyt_pkg.sv | 39 +++
 rtl/dyt_imm_gen.sv | 24 ++
 rtl/dyt_decode_stage.sv | 197 +++++++++++++++++++
 tb/tb_dyt_decode_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dyt_pkg.sv
// Shared RV32E decode constants, op-class and immediate-format encodings.
package dyt_pkg;

    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OP_IMM  = 4'd7,
        CLS_OP      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } opclass_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/dyt_imm_gen.sv
// Combinational immediate extraction; opcode bits are not needed here.
module dyt_imm_gen
    import dyt_pkg::*;
(
    input  logic [31:7] bits,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'h0;
        unique case (fmt)
            IMM_I: imm = {{20{bits[31]}}, bits[31:20]};
            IMM_S: imm = {{20{bits[31]}}, bits[31:25], bits[11:7]};
            IMM_B: imm = {{19{bits[31]}}, bits[31], bits[7],
                          bits[30:25], bits[11:8], 1'b0};
            IMM_U: imm = {bits[31:12], 12'h0};
            IMM_J: imm = {{11{bits[31]}}, bits[31], bits[19:12],
                          bits[20], bits[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/dyt_decode_stage.sv
// RV32E decode stage: field decode, RAW scoreboard stall, ID/EX register.
module dyt_decode_stage
    import dyt_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          REG_AW   = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic [REG_AW-1:0] rf_a_addr,
    output logic [REG_AW-1:0] rf_b_addr,
    input  logic [XLEN-1:0]   rf_a_data,
    input  logic [XLEN-1:0]   rf_b_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [3:0]        ex_opclass,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_we,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [31:0]       ex_imm,
    output logic              ex_illegal,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              flush
);

    localparam int NR = 1 << REG_AW;

    logic [6:0]        opc;
    logic [REG_AW-1:0] rs1, rs2, rd;
    opclass_e          cls_raw, cls;
    imm_fmt_e          fmt_raw, fmt;
    logic              use1, use2, use_rd;
    logic              bad_reg, illegal;
    logic              rd_we;
    logic              haz1, haz2, hazard;
    logic              accept, ex_fire;
    logic [31:0]       imm;
    logic [NR-1:0]     sb, sb_n;
    opclass_e          ex_cls;

    assign opc = if_instr[6:0];
    assign rs1 = if_instr[15 +: REG_AW];
    assign rs2 = if_instr[20 +: REG_AW];
    assign rd  = if_instr[7 +: REG_AW];

    assign rf_a_addr = rs1;
    assign rf_b_addr = rs2;

    always_comb begin
        cls_raw = CLS_ILLEGAL;
        fmt_raw = IMM_NONE;
        use1    = 1'b0;
        use2    = 1'b0;
        use_rd  = 1'b0;
        unique case (opc)
            OPC_LUI: begin
                cls_raw = CLS_LUI;
                fmt_raw = IMM_U;
                use_rd  = 1'b1;
            end
            OPC_AUIPC: begin
                cls_raw = CLS_AUIPC;
                fmt_raw = IMM_U;
                use_rd  = 1'b1;
            end
            OPC_JAL: begin
                cls_raw = CLS_JAL;
                fmt_raw = IMM_J;
                use_rd  = 1'b1;
            end
            OPC_JALR: begin
                cls_raw = CLS_JALR;
                fmt_raw = IMM_I;
                use1    = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_BRANCH: begin
                cls_raw = CLS_BRANCH;
                fmt_raw = IMM_B;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            OPC_LOAD: begin
                cls_raw = CLS_LOAD;
                fmt_raw = IMM_I;
                use1    = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_STORE: begin
                cls_raw = CLS_STORE;
                fmt_raw = IMM_S;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            OPC_OP_IMM: begin
                cls_raw = CLS_OP_IMM;
                fmt_raw = IMM_I;
                use1    = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_OP: begin
                cls_raw = CLS_OP;
                use1    = 1'b1;
                use2    = 1'b1;
                use_rd  = 1'b1;
            end
            default: cls_raw = CLS_ILLEGAL;
        endcase
    end

    // Register fields above x15 are only illegal where the field is used.
    assign bad_reg = (use1   && if_instr[19]) ||
                     (use2   && if_instr[24]) ||
                     (use_rd && if_instr[11]);
    assign illegal = (cls_raw == CLS_ILLEGAL) || bad_reg;
    assign cls     = illegal ? CLS_ILLEGAL : cls_raw;
    assign fmt     = illegal ? IMM_NONE : fmt_raw;
    assign rd_we   = use_rd && !illegal && (rd != '0);

    dyt_imm_gen u_imm (
        .bits (if_instr[31:7]),
        .fmt  (fmt),
        .imm  (imm)
    );

    assign haz1 = use1 && !illegal && (rs1 != '0) &&
                  (sb[rs1] || (ex_valid && ex_rd_we && ex_rd == rs1));
    assign haz2 = use2 && !illegal && (rs2 != '0) &&
                  (sb[rs2] || (ex_valid && ex_rd_we && ex_rd == rs2));
    assign hazard = haz1 || haz2;

    assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    assign accept   = if_valid && if_ready;
    assign ex_fire  = ex_valid && ex_ready && !flush;

    // Set is applied after clear so a same-index collision keeps the bit.
    always_comb begin
        sb_n = sb;
        if (wb_en && wb_addr != '0)
            sb_n[wb_addr] = 1'b0;
        if (ex_fire && ex_rd_we)
            sb_n[ex_rd] = 1'b1;
        sb_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sb <= '0;
        else
            sb <= sb_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= PC_RESET[XLEN-1:0];
            ex_cls      <= CLS_LUI;
            ex_funct3   <= 3'h0;
            ex_funct7b5 <= 1'b0;
            ex_rd       <= '0;
            ex_rd_we    <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= 32'h0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_cls      <= cls;
            ex_funct3   <= if_instr[14:12];
            ex_funct7b5 <= if_instr[30];
            ex_rd       <= rd;
            ex_rd_we    <= rd_we;
            ex_rs1_data <= rf_a_data;
            ex_rs2_data <= rf_b_data;
            ex_imm      <= imm;
            ex_illegal  <= illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_opclass = ex_cls;

endmodule

// File: tb/tb_dyt_decode_stage.sv
// Directed-vector bench for dyt_decode_stage with a tiny register file model.
module tb_dyt_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [3:0]  rf_a_addr, rf_b_addr;
    logic [31:0] rf_a_data, rf_b_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [3:0]  ex_opclass;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [3:0]  ex_rd;
    logic        ex_rd_we;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [31:0] ex_imm;
    logic        ex_illegal;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic        flush;

    logic [31:0] rf [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign rf_a_data = rf[rf_a_addr];
    assign rf_b_data = rf[rf_b_addr];

    always #5 clk = ~clk;

    dyt_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .rf_a_addr   (rf_a_addr),
        .rf_b_addr   (rf_b_addr),
        .rf_a_data   (rf_a_data),
        .rf_b_data   (rf_b_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_pc       (ex_pc),
        .ex_opclass  (ex_opclass),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5),
        .ex_rd       (ex_rd),
        .ex_rd_we    (ex_rd_we),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_illegal  (ex_illegal),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .flush       (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        wb_en    = 1'b0;
        wb_addr  = 4'd0;
        flush    = 1'b0;
        #7;
        rst = 1'b1;
        tick();
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        settle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rf[1] = 32'h11;
        rf[2] = 32'h22;
        rst      = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h00500093;
        if_pc    = 32'h100;
        ex_ready = 1'b1;
        wb_en    = 1'b0;
        wb_addr  = 4'd0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_rd_we", {31'b0, ex_rd_we}, 32'd0);
        chk("rst_illegal", {31'b0, ex_illegal}, 32'd0);
        chk("rst_imm", ex_imm, 32'h0);
        chk("rst_rf_a_addr", {28'b0, rf_a_addr}, 32'd0);

        rst = 1'b1;
        present(32'h00500093, 32'h100);
        chk("addi1_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("addi1_valid", {31'b0, ex_valid}, 32'd1);
        chk("addi1_cls", {28'b0, ex_opclass}, 32'd7);
        chk("addi1_rd", {28'b0, ex_rd}, 32'd1);
        chk("addi1_imm", ex_imm, 32'd5);
        chk("addi1_we", {31'b0, ex_rd_we}, 32'd1);
        chk("addi1_pc", ex_pc, 32'h100);

        present(32'h00900113, 32'h104);
        chk("addi2_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("addi2_valid", {31'b0, ex_valid}, 32'd1);
        chk("addi2_rd", {28'b0, ex_rd}, 32'd2);
        chk("addi2_pc", ex_pc, 32'h104);

        present(32'h00700193, 32'h108);
        chk("addi3_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("addi3_imm", ex_imm, 32'd7);

        present(32'h00318233, 32'h10C);
        chk("raw_ex_stall", {31'b0, if_ready}, 32'd0);
        tick();
        chk("raw_drained", {31'b0, ex_valid}, 32'd0);
        chk("raw_sb_stall", {31'b0, if_ready}, 32'd0);
        tick();
        wb_en   = 1'b1;
        wb_addr = 4'd3;
        settle();
        chk("raw_wb_cycle", {31'b0, if_ready}, 32'd0);
        tick();
        wb_en = 1'b0;
        rf[3] = 32'd7;
        settle();
        chk("raw_release", {31'b0, if_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_cls", {28'b0, ex_opclass}, 32'd8);
        chk("add_rs1", ex_rs1_data, 32'd7);
        chk("add_rs2", ex_rs2_data, 32'd7);
        chk("add_rd", {28'b0, ex_rd}, 32'd4);
        chk("add_imm", ex_imm, 32'h0);

        do_reset();
        present(32'hFE20AE23, 32'h200);
        chk("sw_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("sw_imm", ex_imm, 32'hFFFFFFFC);
        chk("sw_cls", {28'b0, ex_opclass}, 32'd6);
        chk("sw_we", {31'b0, ex_rd_we}, 32'd0);
        chk("sw_f3", {29'b0, ex_funct3}, 32'd2);
        chk("sw_rs2", ex_rs2_data, 32'h22);
        present(32'hFE000CE3, 32'h204);
        tick();
        chk("beq_imm", ex_imm, 32'hFFFFFFF8);
        chk("beq_cls", {28'b0, ex_opclass}, 32'd4);
        present(32'hABCDE2B7, 32'h208);
        tick();
        chk("lui_imm", ex_imm, 32'hABCDE000);
        chk("lui_rd", {28'b0, ex_rd}, 32'd5);
        present(32'h001000EF, 32'h20C);
        tick();
        chk("jal_imm", ex_imm, 32'h00000800);
        chk("jal_cls", {28'b0, ex_opclass}, 32'd2);

        do_reset();
        present(32'h00100893, 32'h300);
        tick();
        chk("x17_illegal", {31'b0, ex_illegal}, 32'd1);
        chk("x17_we", {31'b0, ex_rd_we}, 32'd0);
        chk("x17_cls", {28'b0, ex_opclass}, 32'd9);
        chk("x17_imm", ex_imm, 32'h0);
        present(32'h0000000F, 32'h304);
        tick();
        chk("fence_illegal", {31'b0, ex_illegal}, 32'd1);
        present(32'h00008113, 32'h308);
        chk("illegal_no_sb", {31'b0, if_ready}, 32'd1);
        tick();
        chk("after_ill_legal", {31'b0, ex_illegal}, 32'd0);
        chk("after_ill_rs1", ex_rs1_data, 32'h11);

        do_reset();
        ex_ready = 1'b0;
        present(32'h00500093, 32'h400);
        tick();
        chk("hold_valid", {31'b0, ex_valid}, 32'd1);
        present(32'h00900113, 32'h404);
        chk("hold_ready", {31'b0, if_ready}, 32'd0);
        tick();
        chk("hold_imm", ex_imm, 32'd5);
        chk("hold_pc", ex_pc, 32'h400);
        flush    = 1'b1;
        ex_ready = 1'b1;
        settle();
        chk("flush_ready", {31'b0, if_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        present(32'h00008113, 32'h408);
        chk("flush_no_sb", {31'b0, if_ready}, 32'd1);
        tick();
        chk("post_flush_pc", ex_pc, 32'h408);

        do_reset();
        present(32'h00100313, 32'h500);
        tick();
        if_valid = 1'b0;
        wb_en    = 1'b1;
        wb_addr  = 4'd6;
        tick();
        wb_en = 1'b0;
        present(32'h000303B3, 32'h504);
        chk("setclr_x6_stall", {31'b0, if_ready}, 32'd0);
        wb_en   = 1'b1;
        wb_addr = 4'd6;
        tick();
        wb_en = 1'b0;
        settle();
        chk("x6_released", {31'b0, if_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
